// File: rtl/clock_phasing.sv
// Quadrature phase generator: divides clk by 4*SLOT_CYCLES and drives four
// registered 50%-duty outputs at 0/90/180/270 degree offsets.
module clock_phasing #(
  parameter int SLOT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  output logic clk_0,
  output logic clk_90,
  output logic clk_180,
  output logic clk_270
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

  if (SLOT_CYCLES < 1) begin : g_bad_param
    $error("clock_phasing: SLOT_CYCLES must be >= 1");
  end

  typedef struct packed {
    logic p0;
    logic p90;
    logic p180;
    logic p270;
  } phase_t;

  logic [CW-1:0] cyc;
  logic [1:0]    slot;
  logic          started;
  phase_t        ph_q;

  function automatic phase_t slot_pat(input logic [1:0] s);
    case (s)
      2'd0:    slot_pat = '{p0: 1'b1, p90: 1'b0, p180: 1'b0, p270: 1'b1};
      2'd1:    slot_pat = '{p0: 1'b1, p90: 1'b1, p180: 1'b0, p270: 1'b0};
      2'd2:    slot_pat = '{p0: 1'b0, p90: 1'b1, p180: 1'b1, p270: 1'b0};
      default: slot_pat = '{p0: 1'b0, p90: 1'b0, p180: 1'b1, p270: 1'b1};
    endcase
  endfunction

  // slot resets to 3 so the first live edge lands in slot 0 via the normal wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc     <= '0;
      slot    <= 2'd3;
      started <= 1'b0;
      ph_q    <= '0;
    end else if (!started || cyc == LAST) begin
      started <= 1'b1;
      cyc     <= '0;
      slot    <= slot + 2'd1;
      ph_q    <= slot_pat(slot + 2'd1);
    end else begin
      cyc <= cyc + 1'b1;
    end
  end

  assign clk_0   = ph_q.p0;
  assign clk_90  = ph_q.p90;
  assign clk_180 = ph_q.p180;
  assign clk_270 = ph_q.p270;

endmodule

// File: tb/tb_clock_phasing.sv
// Directed bench for clock_phasing at N=1, 3 and 5 sharing one clock and reset.
module tb_clock_phasing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic c0_1, c90_1, c180_1, c270_1;
  logic c0_3, c90_3, c180_3, c270_3;
  logic c0_5, c90_5, c180_5, c270_5;

  clock_phasing #(.SLOT_CYCLES(1)) u_n1 (
    .clk(clk), .rst(rst), .clk_0(c0_1), .clk_90(c90_1), .clk_180(c180_1), .clk_270(c270_1));
  clock_phasing #(.SLOT_CYCLES(3)) u_n3 (
    .clk(clk), .rst(rst), .clk_0(c0_3), .clk_90(c90_3), .clk_180(c180_3), .clk_270(c270_3));
  clock_phasing #(.SLOT_CYCLES(5)) u_n5 (
    .clk(clk), .rst(rst), .clk_0(c0_5), .clk_90(c90_5), .clk_180(c180_5), .clk_270(c270_5));

  // each bundle is {clk_0, clk_90, clk_180, clk_270}
  logic [3:0] o1, o3, o5;
  assign o1 = {c0_1, c90_1, c180_1, c270_1};
  assign o3 = {c0_3, c90_3, c180_3, c270_3};
  assign o5 = {c0_5, c90_5, c180_5, c270_5};

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic [3:0] e1;
    logic [3:0] e3;
    logic [3:0] e5;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [3:0] pat(input int s);
    case (s % 4)
      0:       pat = 4'b1001;
      1:       pat = 4'b1100;
      2:       pat = 4'b0110;
      default: pat = 4'b0011;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // drive rst, take one rising edge, sample on the following falling edge
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] prev5;
  int last_chg [4];
  int last_rise [4];
  int hi_len;

  initial begin
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 4'b1001, 4'b1001, 4'b1001};
    tbl[2]  = '{1'b0, 4'b1100, 4'b1001, 4'b1001};
    tbl[3]  = '{1'b0, 4'b0110, 4'b1001, 4'b1001};
    tbl[4]  = '{1'b0, 4'b0011, 4'b1100, 4'b1001};
    tbl[5]  = '{1'b0, 4'b1001, 4'b1100, 4'b1001};
    tbl[6]  = '{1'b0, 4'b1100, 4'b1100, 4'b1100};
    tbl[7]  = '{1'b0, 4'b0110, 4'b0110, 4'b1100};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 4'b1001, 4'b1001, 4'b1001};
    tbl[11] = '{1'b0, 4'b1100, 4'b1001, 4'b1001};
    tbl[12] = '{1'b0, 4'b0110, 4'b1001, 4'b1001};
    tbl[13] = '{1'b0, 4'b0011, 4'b1100, 4'b1001};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst);
      chk($sformatf("vec%0d_n1", i), o1, tbl[i].e1);
      chk($sformatf("vec%0d_n3", i), o3, tbl[i].e3);
      chk($sformatf("vec%0d_n5", i), o5, tbl[i].e5);
    end

    // long reset hold: everything parked at zero
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      chk("rst_hold_n1", o1, 4'b0000);
      chk("rst_hold_n3", o3, 4'b0000);
      chk("rst_hold_n5", o5, 4'b0000);
    end

    prev5  = 4'b0000;
    hi_len = 0;
    for (int j = 0; j < 4; j++) begin
      last_chg[j]  = 0;
      last_rise[j] = 0;
    end

    for (int k = 1; k <= 1000; k++) begin
      step(1'b0);
      chk("run_n1", o1, pat(k - 1));
      chk("run_n3", o3, pat((k - 1) / 3));
      chk("run_n5", o5, pat((k - 1) / 5));

      if (k <= 20) begin
        chk_int("n1_two_high", $countones(o1), 2);
        chk("n1_inverse", {c180_1, c270_1}, {~c0_1, ~c90_1});
        if (c0_1) hi_len++;
        else if (hi_len != 0) begin
          chk_int("n1_high_len", hi_len, 2);
          hi_len = 0;
        end
      end

      if (c90_3 && k > 1 && ((k - 1) % 12) == 3)
        chk_int("n3_90_after_0", k - (((k - 1) / 12) * 12 + 1), 3);

      for (int j = 0; j < 4; j++) begin
        if (o5[3-j] != prev5[3-j]) begin
          if (last_chg[j] > 1) chk_int($sformatf("n5_toggle_ival%0d", j), k - last_chg[j], 10);
          last_chg[j] = k;
          if (o5[3-j]) begin
            last_rise[j] = k;
            if (j > 0 && k > 1) chk_int($sformatf("n5_phase%0d", j), k - last_rise[0], 5 * j);
          end
        end
      end
      prev5 = o5;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
